// File: rtl/rv_rtype_multicycle.sv
// ---------------------------------------------------------------------------
// rv_rtype_multicycle
//   Multi-cycle RV32/RV64 R-type execution core. Instructions are fetched from
//   an internal word-addressed memory, then executed through a fixed
//   FETCH -> DECODE -> EXECUTE -> WRITEBACK sequence. All ten base R-type
//   operations are supported. Execution halts on a zero word, on the last
//   memory word, or on an illegal encoding.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   imem_we/waddr/wdata   instruction memory write port (ignored while busy)
//   dbg_we/addr/wdata     register-file write port (ignored while busy, x0)
//   dbg_rdata             registered read of x[dbg_addr], 1-cycle latency
//   start                 begin at PC 0 (only from IDLE or HALT)
//   busy, halted          FSM status
//   illegal               halt was caused by an illegal encoding
//   retire_valid/pc/rd/data  one-cycle retirement report per instruction
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | after reset; debug/imem writes accepted, waiting for start
// FETCH     | ir <- imem[pc]
// DECODE    | legality check / halt decision, latch source operands
// EXECUTE   | ALU result computed and registered
// WRITEBACK | register write, retire report, pc advance or end-of-memory
// HALT      | stopped; writes accepted, start restarts from PC 0
// ---------------------------------------------------------------------------
module rv_rtype_multicycle #(
   parameter int XLEN       = 32,
   parameter int IMEM_WORDS = 16,
   localparam int SHW       = $clog2(XLEN),
   localparam int AW        = $clog2(IMEM_WORDS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            imem_we,
   input  logic [AW-1:0]   imem_waddr,
   input  logic [31:0]     imem_wdata,
   input  logic            dbg_we,
   input  logic [4:0]      dbg_addr,
   input  logic [XLEN-1:0] dbg_wdata,
   output logic [XLEN-1:0] dbg_rdata,
   input  logic            start,
   output logic            busy,
   output logic            halted,
   output logic            illegal,
   output logic            retire_valid,
   output logic [31:0]     retire_pc,
   output logic [4:0]      retire_rd,
   output logic [XLEN-1:0] retire_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_t;

   localparam logic [6:0]  OPC_OP = 7'b0110011;
   localparam logic [31:0] PC_END = 32'(4 * IMEM_WORDS);

   state_t          state, state_nxt;

   logic [31:0]     imem [IMEM_WORDS];
   logic [XLEN-1:0] rf   [32];

   logic [31:0]     pc;
   logic [31:0]     ir;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] result;
   logic [XLEN-1:0] alu_out;

   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic [2:0]      funct3;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [6:0]      funct7;
   logic            enc_legal;
   logic [31:0]     pc_plus4;
   logic            last_word;
   logic [SHW-1:0]  shamt;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign funct7 = ir[31:25];

   // funct7=0100000 only selects SUB and SRA
   assign enc_legal = (opcode == OPC_OP) &&
                      ((funct7 == 7'b0000000) ||
                       ((funct7 == 7'b0100000) &&
                        ((funct3 == 3'b000) || (funct3 == 3'b101))));

   assign pc_plus4  = pc + 32'd4;
   assign last_word = (pc_plus4 == PC_END);
   assign shamt     = op_b[SHW-1:0];

   assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                   (state == S_EXECUTE) || (state == S_WRITEBACK);
   assign halted = (state == S_HALT);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_HALT: begin
            if (start) state_nxt = S_FETCH;
         end
         S_FETCH: state_nxt = S_DECODE;
         S_DECODE: begin
            if ((ir == 32'd0) || !enc_legal) state_nxt = S_HALT;
            else                             state_nxt = S_EXECUTE;
         end
         S_EXECUTE: state_nxt = S_WRITEBACK;
         S_WRITEBACK: begin
            if (last_word) state_nxt = S_HALT;
            else           state_nxt = S_FETCH;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // ALU
   // -------------------------------------------------------------------------
   always_comb begin
      alu_out = '0;
      case (funct3)
         3'b000: alu_out = funct7[5] ? (op_a - op_b) : (op_a + op_b);
         3'b001: alu_out = op_a << shamt;
         3'b010: alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         3'b011: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         3'b100: alu_out = op_a ^ op_b;
         3'b101: alu_out = funct7[5] ? XLEN'($signed(op_a) >>> shamt)
                                     : (op_a >> shamt);
         3'b110: alu_out = op_a | op_b;
         3'b111: alu_out = op_a & op_b;
         default: alu_out = '0;
      endcase
   end

   // -------------------------------------------------------------------------
   // Instruction memory: contents survive reset so a program can be rerun.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (imem_we && !busy) imem[imem_waddr] <= imem_wdata;
   end

   // -------------------------------------------------------------------------
   // Datapath, register file and retire reporting
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc           <= '0;
         ir           <= '0;
         op_a         <= '0;
         op_b         <= '0;
         result       <= '0;
         illegal      <= 1'b0;
         dbg_rdata    <= '0;
         retire_valid <= 1'b0;
         retire_pc    <= '0;
         retire_rd    <= '0;
         retire_data  <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         retire_valid <= 1'b0;
         // Sampled before any same-edge write, so a read during WRITEBACK
         // still returns the old value.
         dbg_rdata    <= (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

         case (state)
            S_IDLE, S_HALT: begin
               if (dbg_we && (dbg_addr != 5'd0)) rf[dbg_addr] <= dbg_wdata;
               if (start) begin
                  pc      <= '0;
                  illegal <= 1'b0;
               end
            end
            S_FETCH: begin
               ir <= imem[pc[2 +: AW]];
            end
            S_DECODE: begin
               op_a <= rf[rs1];
               op_b <= rf[rs2];
               if ((ir != 32'd0) && !enc_legal) illegal <= 1'b1;
            end
            S_EXECUTE: begin
               result <= alu_out;
            end
            S_WRITEBACK: begin
               if (rd != 5'd0) rf[rd] <= result;
               retire_valid <= 1'b1;
               retire_pc    <= pc;
               retire_rd    <= rd;
               retire_data  <= result;
               if (!last_word) pc <= pc_plus4;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_rtype_multicycle.sv
module tb_rv_rtype_multicycle;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_we;
   logic [3:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        dbg_we;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic [31:0] dbg_rdata;
   logic        start;
   logic        busy;
   logic        halted;
   logic        illegal;
   logic        retire_valid;
   logic [31:0] retire_pc;
   logic [4:0]  retire_rd;
   logic [31:0] retire_data;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   last_ret_cyc = 0;

   rv_rtype_multicycle #(.XLEN(32), .IMEM_WORDS(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_we      (imem_we),
      .imem_waddr   (imem_waddr),
      .imem_wdata   (imem_wdata),
      .dbg_we       (dbg_we),
      .dbg_addr     (dbg_addr),
      .dbg_wdata    (dbg_wdata),
      .dbg_rdata    (dbg_rdata),
      .start        (start),
      .busy         (busy),
      .halted       (halted),
      .illegal      (illegal),
      .retire_valid (retire_valid),
      .retire_pc    (retire_pc),
      .retire_rd    (retire_rd),
      .retire_data  (retire_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every retirement is popped and compared here.
   always @(negedge clk) begin
      if (!reset && retire_valid === 1'b1) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_retire pc=%h rd=%0d data=%h required no retire",
                     retire_pc, retire_rd, retire_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (retire_pc !== e.pc || retire_rd !== e.rd || retire_data !== e.data) begin
               miscompares++;
               $display("FAIL retire pc=%h rd=%0d data=%h required pc=%h rd=%0d data=%h",
                        retire_pc, retire_rd, retire_data, e.pc, e.rd, e.data);
            end
            if (e.pc != 32'd0) begin
               vectors++;
               if (cyc - last_ret_cyc != 4) begin
                  miscompares++;
                  $display("FAIL retire_spacing got %0d cycles required 4",
                           cyc - last_ret_cyc);
               end
            end
            last_ret_cyc = cyc;
         end
      end
   end

   function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   task automatic imem_write(input logic [3:0] a, input logic [31:0] w);
      @(negedge clk);
      imem_we = 1'b1; imem_waddr = a; imem_wdata = w;
      @(negedge clk);
      imem_we = 1'b0;
   endtask

   task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
      @(negedge clk);
      dbg_we = 1'b0;
   endtask

   task automatic dbg_read(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      dbg_addr = a;
      @(negedge clk);
      d = dbg_rdata;
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
      exp_t e;
      e.pc = pc; e.rd = rd; e.data = d;
      sb.push_back(e);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halt(input int budget, output bit with_retire);
      bit got = 0;
      int n   = 0;
      with_retire = 0;
      while (n < budget && !got) begin
         @(negedge clk);
         n++;
         if (halted === 1'b1) begin
            got = 1;
            with_retire = (retire_valid === 1'b1);
         end
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL halt_timeout halted=%b required 1 within %0d cycles", halted, budget);
      end
      @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL missing_retires left=%0d required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic run_prog(input int budget, output bit with_retire);
      pulse_start();
      wait_halt(budget, with_retire);
   endtask

   task automatic check_reg(input string name, input logic [4:0] a, input logic [31:0] req);
      logic [31:0] d;
      dbg_read(a, d);
      vectors++;
      if (d !== req) begin
         miscompares++;
         $display("FAIL %s x%0d=%h required %h", name, a, d, req);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      vectors++;
      if ({busy, halted, illegal, retire_valid} !== 4'b0 || retire_pc !== 32'd0 ||
          retire_rd !== 5'd0 || retire_data !== 32'd0 || dbg_rdata !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_outputs busy=%b halted=%b illegal=%b rv=%b pc=%h rd=%0d data=%h dbg=%h required all 0",
                  busy, halted, illegal, retire_valid, retire_pc, retire_rd, retire_data, dbg_rdata);
      end
      check_reg("reset_rf", 5'd7, 32'd0);
   endtask

   task automatic test_basic_add();
      dbg_write(5'd5, 32'd3);
      dbg_write(5'd6, 32'd3);
      imem_write(4'd0, 32'h006283B3);
      imem_write(4'd1, 32'd0);
      push_exp(32'd0, 5'd7, 32'd6);
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         vectors++;
         if (retire_valid !== logic'(c == 5) || halted !== logic'(c == 7) ||
             busy !== logic'(c <= 6)) begin
            miscompares++;
            $display("FAIL basic_timing cycle=%0d rv=%b halted=%b busy=%b required rv=%b halted=%b busy=%b",
                     c, retire_valid, halted, busy, c == 5, c == 7, c <= 6);
         end
      end
      vectors++;
      if (illegal !== 1'b0 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL basic_halt illegal=%b pending=%0d required 0 0", illegal, sb.size());
         sb.delete();
      end
      check_reg("basic_x7", 5'd7, 32'd6);
   endtask

   task automatic test_compare_sub();
      bit wr;
      dbg_write(5'd5, 32'd3);
      dbg_write(5'd6, 32'd5);
      imem_write(4'd0, rtype(7'h20, 5'd6, 5'd5, 3'd0, 5'd1));
      imem_write(4'd1, rtype(7'h00, 5'd6, 5'd5, 3'd2, 5'd2));
      imem_write(4'd2, rtype(7'h00, 5'd6, 5'd5, 3'd3, 5'd3));
      imem_write(4'd3, 32'd0);
      push_exp(32'd0, 5'd1, 32'hFFFF_FFFE);
      push_exp(32'd4, 5'd2, 32'd1);
      push_exp(32'd8, 5'd3, 32'd1);
      run_prog(60, wr);
      vectors++;
      if (illegal !== 1'b0) begin
         miscompares++;
         $display("FAIL cmp_illegal got %b required 0", illegal);
      end
      check_reg("sub_x1", 5'd1, 32'hFFFF_FFFE);
   endtask

   task automatic test_shifts();
      bit wr;
      dbg_write(5'd5, 32'h8000_0000);
      dbg_write(5'd6, 32'h21);
      imem_write(4'd0, rtype(7'h20, 5'd6, 5'd5, 3'd5, 5'd8));
      imem_write(4'd1, rtype(7'h00, 5'd6, 5'd5, 3'd5, 5'd9));
      imem_write(4'd2, rtype(7'h00, 5'd6, 5'd5, 3'd1, 5'd10));
      imem_write(4'd3, 32'd0);
      push_exp(32'd0, 5'd8,  32'hC000_0000);
      push_exp(32'd4, 5'd9,  32'h4000_0000);
      push_exp(32'd8, 5'd10, 32'h0000_0000);
      run_prog(60, wr);
      check_reg("sra_x8", 5'd8, 32'hC000_0000);
   endtask

   task automatic test_x0_illegal();
      bit wr;
      dbg_write(5'd5, 32'd3);
      dbg_write(5'd6, 32'd5);
      imem_write(4'd0, rtype(7'h00, 5'd6, 5'd5, 3'd0, 5'd0));
      imem_write(4'd1, rtype(7'h01, 5'd6, 5'd5, 3'd0, 5'd4));
      push_exp(32'd0, 5'd0, 32'd8);
      run_prog(60, wr);
      vectors++;
      if (halted !== 1'b1 || illegal !== 1'b1) begin
         miscompares++;
         $display("FAIL funct7_illegal halted=%b illegal=%b required 1 1", halted, illegal);
      end
      check_reg("x0_zero", 5'd0, 32'd0);
      check_reg("illegal_no_write", 5'd4, 32'd0);
      check_reg("regs_unchanged", 5'd1, 32'hFFFF_FFFE);
      // bad opcode (addi), then funct7=0100000 with funct3=001
      imem_write(4'd0, 32'h0000_0013);
      run_prog(60, wr);
      vectors++;
      if (illegal !== 1'b1) begin
         miscompares++;
         $display("FAIL opcode_illegal got %b required 1", illegal);
      end
      imem_write(4'd0, rtype(7'h20, 5'd6, 5'd5, 3'd1, 5'd4));
      run_prog(60, wr);
      vectors++;
      if (illegal !== 1'b1) begin
         miscompares++;
         $display("FAIL f7_f3_illegal got %b required 1", illegal);
      end
   endtask

   task automatic test_end_of_memory();
      bit wr;
      dbg_write(5'd1, 32'd0);
      dbg_write(5'd2, 32'd1);
      for (int i = 0; i < 16; i++) begin
         imem_write(4'(i), rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd1));
         push_exp(32'(4 * i), 5'd1, 32'(i + 1));
      end
      run_prog(100, wr);
      vectors++;
      if (wr !== 1'b1 || illegal !== 1'b0) begin
         miscompares++;
         $display("FAIL eom_halt retire_with_halt=%b illegal=%b required 1 0", wr, illegal);
      end
      check_reg("eom_x1", 5'd1, 32'd16);
   endtask

   task automatic test_reset_mid();
      dbg_write(5'd5, 32'd3);
      dbg_write(5'd6, 32'd3);
      dbg_write(5'd7, 32'h55);
      imem_write(4'd0, 32'h006283B3);
      imem_write(4'd1, 32'd0);
      pulse_start();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      vectors++;
      if ({busy, halted, illegal, retire_valid} !== 4'b0 || retire_pc !== 32'd0 ||
          retire_rd !== 5'd0 || retire_data !== 32'd0 || dbg_rdata !== 32'd0) begin
         miscompares++;
         $display("FAIL midreset_outputs busy=%b halted=%b illegal=%b rv=%b pc=%h rd=%0d data=%h dbg=%h required all 0",
                  busy, halted, illegal, retire_valid, retire_pc, retire_rd, retire_data, dbg_rdata);
      end
      @(negedge clk);
      reset = 1'b0;
      check_reg("midreset_x7", 5'd7, 32'd0);
   endtask

   task automatic test_back_to_back();
      bit wr;
      dbg_write(5'd5, 32'd2);
      dbg_write(5'd6, 32'd7);
      imem_write(4'd0, rtype(7'h00, 5'd6, 5'd5, 3'd0, 5'd7));
      imem_write(4'd1, rtype(7'h00, 5'd7, 5'd7, 3'd0, 5'd8));
      imem_write(4'd2, 32'd0);
      push_exp(32'd0, 5'd7, 32'd9);
      push_exp(32'd4, 5'd8, 32'd18);
      pulse_start();
      imem_write(4'd1, 32'd0);
      imem_write(4'd2, rtype(7'h00, 5'd6, 5'd5, 3'd0, 5'd9));
      dbg_write(5'd5, 32'd100);
      wait_halt(60, wr);
      check_reg("blocked_dbg_x5", 5'd5, 32'd2);
      check_reg("dependent_x8", 5'd8, 32'd18);
      push_exp(32'd0, 5'd7, 32'd9);
      push_exp(32'd4, 5'd8, 32'd18);
      run_prog(60, wr);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
      dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      test_reset();
      test_basic_add();
      test_compare_sub();
      test_shifts();
      test_x0_illegal();
      test_end_of_memory();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
